// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access lengths, exception causes
// and FSM states.
package lsu_pkg;

  localparam logic [1:0] ML_BYTE = 2'b00;
  localparam logic [1:0] ML_HALF = 2'b01;
  localparam logic [1:0] ML_WORD = 2'b10;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LWAIT = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_check.sv
// Combinational access checker: reports the highest-priority exception for a
// request (illegal encoding, then misalignment, then out-of-range address).
module lsu_check
  import lsu_pkg::*;
#(
  parameter int ADDRW = 12
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        exc,
  output logic [3:0]  cause
);

  logic w_illegal;
  logic w_misalign;
  logic w_range;

  always_comb begin
    w_illegal  = (funct3[1:0] == 2'b11) || (we && funct3[2]);
    w_misalign = ((funct3[1:0] == ML_HALF) && addr[0]) ||
                 ((funct3[1:0] == ML_WORD) && (addr[1:0] != 2'b00));
    // Shifting keeps every address bit in the expression.
    w_range    = ((addr >> ADDRW) != 32'd0);
    exc   = 1'b0;
    cause = 4'd0;
    if (w_illegal) begin
      exc   = 1'b1;
      cause = EXC_ILLEGAL;
    end else if (w_misalign) begin
      exc   = 1'b1;
      cause = we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end else if (w_range) begin
      exc   = 1'b1;
      cause = we ? EXC_ST_FAULT : EXC_LD_FAULT;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one MEM-stage access at a time, checks it, drives the
// synchronous data memory and returns load data or an exception.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDRW = 12
) (
  input  logic             clk,
  input  logic             rst,
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable while valid is high and ready is low.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_exc,
  output logic [3:0]       resp_cause,
  output logic             mem_we,
  output logic [2:0]       mem_funct3,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output lsu_state_e       dbg_state
);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic             w_accept;
  logic             w_exc;
  logic [3:0]       w_cause;
  logic             r_we;
  logic             r_exc;
  logic [3:0]       r_cause;
  logic [31:0]      r_rdata;
  logic [ADDRW-1:0] r_mem_addr;
  logic [2:0]       r_mem_funct3;
  logic [31:0]      r_mem_wdata;

  lsu_check #(.ADDRW(ADDRW)) u_check (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .exc    (w_exc),
    .cause  (w_cause)
  );

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_exc ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        // Gated by reset so an abandoned store never reaches memory.
        mem_we = r_we && !rst;
        w_next = r_we ? S_RESP : S_LWAIT;
      end
      S_LWAIT: w_next = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_exc        <= 1'b0;
      r_cause      <= 4'd0;
      r_rdata      <= 32'd0;
      r_mem_addr   <= '0;
      r_mem_funct3 <= 3'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_exc   <= w_exc;
        r_cause <= w_cause;
        r_rdata <= 32'd0;
        // Faulting accesses leave the memory-side bus untouched.
        if (!w_exc) begin
          r_mem_addr   <= req_addr[ADDRW-1:0];
          r_mem_funct3 <= req_funct3;
          r_mem_wdata  <= req_wdata;
        end
      end
      if (r_state == S_LWAIT) r_rdata <= mem_rdata;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_exc   = r_exc;
  assign resp_cause = r_cause;
  assign mem_addr   = r_mem_addr;
  assign mem_funct3 = r_mem_funct3;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array data memory behind the DUT, a byte-level reference
// model of every access, directed scenarios and randomized traffic.
module tb_lsu;
  import lsu_pkg::*;

  localparam int ADDRW = 12;
  localparam int MSIZE = 1 << ADDRW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = 3'd0;
  logic [31:0]      req_addr = 32'd0;
  logic [31:0]      req_wdata = 32'd0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_rdata;
  logic             resp_exc;
  logic [3:0]       resp_cause;
  logic             mem_we;
  logic [2:0]       mem_funct3;
  logic [ADDRW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = 32'd0;
  lsu_state_e       dbg_state;

  logic             c_we = 1'b0;
  logic [2:0]       c_f3 = 3'd0;
  logic [31:0]      c_addr = 32'd0;
  logic             c_exc;
  logic [3:0]       c_cause;

  int total = 0;
  int bad = 0;
  int we_pulses = 0;

  logic [7:0] mem     [MSIZE];
  logic [7:0] ref_mem [MSIZE];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  lsu #(.ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_cause(resp_cause),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  lsu_check #(.ADDRW(ADDRW)) u_chk (
    .we(c_we), .funct3(c_f3), .addr(c_addr), .exc(c_exc), .cause(c_cause)
  );

  // ---------------- access rules, written from the byte-level view
  function automatic int len_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int len, input logic uns);
    if (len == 1 && !uns && v[7])  return v | 32'hFFFF_FF00;
    if (len == 2 && !uns && v[15]) return v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           output logic exc, output logic [3:0] cause);
    int len;
    len = len_of(f3);
    exc = 1'b1;
    if (len == 0 || (we && f3[2]))        cause = 4'd2;
    else if ((a % 32'(len)) != 0)         cause = we ? 4'd6 : 4'd4;
    else if (a >= 32'(MSIZE))             cause = we ? 4'd7 : 4'd5;
    else begin exc = 1'b0; cause = 4'd0; end
  endtask

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic exc, output logic [3:0] cause, output int lat);
    int len;
    logic [31:0] v;
    len = len_of(f3);
    exp_fault(we, f3, a, exc, cause);
    rd = 32'd0;
    v  = 32'd0;
    if (exc) lat = 1;
    else if (we) begin
      for (int i = 0; i < len; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      lat = 2;
    end else begin
      for (int i = 0; i < len; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      rd  = extend(v, len, f3[2]);
      lat = 3;
    end
  endtask

  // ---------------- data memory the DUT drives (synchronous read)
  always @(posedge clk) begin
    logic [31:0] v;
    int len;
    len = len_of(mem_funct3);
    v = 32'd0;
    for (int i = 0; i < len; i++) v[8*i +: 8] = mem[(int'(mem_addr) + i) % MSIZE];
    mem_rdata <= extend(v, len, mem_funct3[2]);
    if (mem_we) begin
      for (int i = 0; i < len; i++) mem[(int'(mem_addr) + i) % MSIZE] = mem_wdata[8*i +: 8];
      we_pulses++;
    end
  end

  // ---------------- driver: one full access with checks against the model
  task automatic run_access(input string name, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int stall,
                            output logic [31:0] rd);
    logic [31:0]      e_rd;
    logic             e_exc;
    logic [3:0]       e_cause;
    int               e_lat, lat, p0, guard, e_pulses;
    logic [ADDRW-1:0] a0;
    ref_access(we, f3, a, wd, e_rd, e_exc, e_cause, e_lat);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    p0 = we_pulses;
    a0 = mem_addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rd = resp_rdata;
    total++;
    if (lat != e_lat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e_lat);
    end
    total++;
    if (resp_rdata !== e_rd) begin
      bad++; $display("FAIL %s rdata got=%h want=%h", name, resp_rdata, e_rd);
    end
    total++;
    if (resp_exc !== e_exc || resp_cause !== e_cause) begin
      bad++; $display("FAIL %s exc/cause got=%b/%0d want=%b/%0d", name, resp_exc, resp_cause, e_exc, e_cause);
    end
    e_pulses = (we && !e_exc) ? 1 : 0;
    total++;
    if (we_pulses - p0 != e_pulses) begin
      bad++; $display("FAIL %s mem_we pulses got=%0d want=%0d", name, we_pulses - p0, e_pulses);
    end
    if (e_exc) begin
      total++;
      if (mem_addr !== a0) begin
        bad++; $display("FAIL %s fault moved mem_addr got=%h want=%h", name, mem_addr, a0);
      end
    end
    // Stall the response while a second request waits.
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== e_rd || resp_exc !== e_exc || req_ready !== 1'b0) begin
        bad++; $display("FAIL %s stall%0d got v=%b rd=%h exc=%b rdy=%b want v=1 rd=%h exc=%b rdy=0",
                        name, s, resp_valid, resp_rdata, resp_exc, req_ready, e_rd, e_exc);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL %s after handshake got rdy=%b v=%b want rdy=1 v=0", name, req_ready, resp_valid);
    end
    req_valid = 1'b0;
  endtask

  // ---------------- scenarios
  task automatic check_reset_values(input string name);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_exc !== 1'b0 || resp_cause !== 4'd0 ||
        resp_rdata !== 32'd0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_funct3 !== 3'd0 ||
        mem_wdata !== 32'd0 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL %s reset values got rdy=%b v=%b exc=%b cause=%0d rd=%h we=%b addr=%h f3=%0d wd=%h st=%0d want rdy=1 rest 0",
               name, req_ready, resp_valid, resp_exc, resp_cause, resp_rdata, mem_we, mem_addr,
               mem_funct3, mem_wdata, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    run_access("sw_010", 1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 0, rd);
    run_access("lw_010", 1'b0, 3'b010, 32'h010, 32'd0, 0, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_010 value got=%h want=deadbeef", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd;
    run_access("sb_013", 1'b1, 3'b000, 32'h013, 32'h0000_0080, 0, rd);
    run_access("lb_013", 1'b0, 3'b000, 32'h013, 32'd0, 0, rd);
    total++;
    if (rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_013 value got=%h want=ffffff80", rd); end
    run_access("lbu_013", 1'b0, 3'b100, 32'h013, 32'd0, 0, rd);
    total++;
    if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu_013 value got=%h want=00000080", rd); end
    run_access("lw_010b", 1'b0, 3'b010, 32'h010, 32'd0, 0, rd);
    total++;
    if (rd !== 32'h80AD_BEEF) begin bad++; $display("FAIL lw_010b value got=%h want=80adbeef", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    run_access("lh_101", 1'b0, 3'b001, 32'h101, 32'd0, 0, rd);
    total++;
    if (resp_cause !== 4'd4 || rd !== 32'd0) begin
      bad++; $display("FAIL lh_101 cause/rdata got=%0d/%h want=4/0", resp_cause, rd);
    end
    run_access("sw_1000", 1'b1, 3'b010, 32'h1000, 32'hCAFE_F00D, 0, rd);
    total++;
    if (resp_cause !== 4'd7) begin bad++; $display("FAIL sw_1000 cause got=%0d want=7", resp_cause); end
    run_access("lw_000", 1'b0, 3'b010, 32'h000, 32'd0, 0, rd);
    run_access("s_f3_100", 1'b1, 3'b100, 32'h020, 32'h1, 0, rd);
    total++;
    if (resp_cause !== 4'd2) begin bad++; $display("FAIL s_f3_100 cause got=%0d want=2", resp_cause); end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    run_access("stall_lw", 1'b0, 3'b010, 32'h010, 32'd0, 5, rd);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int p0;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h020; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_mid issue mem_we got=%b want=1", mem_we); end
    p0 = we_pulses;
    rst = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mid gated mem_we got=%b want=0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (we_pulses != p0) begin bad++; $display("FAIL rst_mid write got=%0d want=0", we_pulses - p0); end
    check_reset_values("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid response got=%b want=0", resp_valid); end
    end
    run_access("lw_020", 1'b0, 3'b010, 32'h020, 32'd0, 0, rd);
  endtask

  task automatic test_check_unit();
    logic       e_exc;
    logic [3:0] e_cause;
    for (int w = 0; w < 2; w++)
      for (int f = 0; f < 8; f++)
        for (int a2 = 0; a2 < 4; a2++)
          for (int hi = 0; hi < 2; hi++) begin
            c_we   = w[0];
            c_f3   = f[2:0];
            c_addr = (32'($urandom_range(0, 1023)) << 2) | 32'(a2);
            if (hi != 0) c_addr = c_addr | (32'h1 << $urandom_range(ADDRW, 31));
            #1;
            exp_fault(c_we, c_f3, c_addr, e_exc, e_cause);
            total++;
            if (c_exc !== e_exc || c_cause !== e_cause) begin
              bad++; $display("FAIL check we=%0d f3=%0d addr=%h got=%b/%0d want=%b/%0d",
                              w, f, c_addr, c_exc, c_cause, e_exc, e_cause);
            end
          end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000;
      run_access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                 $urandom_range(0, 2), rd);
    end
  endtask

  // ---------------- sequence and report
  initial begin
    for (int i = 0; i < MSIZE; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    @(negedge clk);
    test_reset();
    test_check_unit();
    test_store_load();
    test_byte();
    test_faults();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
